// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - IDLE/RUN/DEAD game FSM with collide filter, restart lockout and speed level
// Optional AUTO_RESTART_EN: DEAD returns to IDLE after a further LOCK_FRAMES idle frame ticks.
module game_state_controller #(
  parameter int unsigned COLLIDE_FRAMES = 2,
  parameter int unsigned LOCK_FRAMES    = 30,
  parameter int unsigned LEVEL_FRAMES   = 600,
  parameter int unsigned MAX_LEVEL      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_clk,
  input  logic       jump,
  input  logic       collide,
  output logic [1:0] state,
  output logic       run,
  output logic       start_pulse,
  output logic       death_pulse,
  output logic [3:0] speed_level
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam logic [3:0]  COLLIDE_LIM = 4'(COLLIDE_FRAMES);
  localparam logic [7:0]  LOCK_INIT   = 8'(LOCK_FRAMES);
  localparam logic [15:0] LEVEL_LAST  = 16'(LEVEL_FRAMES - 1);
  localparam logic [3:0]  LEVEL_MAX   = 4'(MAX_LEVEL);

  logic [1:0] frame_sync;
  logic [1:0] jump_sync;
  logic [1:0] collide_sync;
  logic [1:0] sync_valid;
  logic       frame_prev;
  logic       jump_prev;
  logic       frame_tick;
  logic       jump_rise;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic        death_q, death_d;
  logic [3:0]  speed_q, speed_d;
  logic [3:0]  collide_cnt_q, collide_cnt_d;
  logic [15:0] level_cnt_q, level_cnt_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
`ifdef AUTO_RESTART_EN
  logic [7:0]  auto_cnt_q, auto_cnt_d;
`endif

  // jump_prev stays 1 until the synchroniser holds a real sample, so a button
  // held through reset release is not seen as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sync   <= 2'b00;
      jump_sync    <= 2'b00;
      collide_sync <= 2'b00;
      sync_valid   <= 2'b00;
      frame_prev   <= 1'b0;
      jump_prev    <= 1'b1;
    end else begin
      frame_sync   <= {frame_sync[0], frame_clk};
      jump_sync    <= {jump_sync[0], jump};
      collide_sync <= {collide_sync[0], collide};
      sync_valid   <= {sync_valid[0], 1'b1};
      frame_prev   <= frame_sync[1];
      jump_prev    <= sync_valid[1] ? jump_sync[1] : 1'b1;
    end
  end

  assign frame_tick = frame_sync[1] & ~frame_prev;
  assign jump_rise  = sync_valid[1] & jump_sync[1] & ~jump_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      death_q       <= 1'b0;
      speed_q       <= 4'd0;
      collide_cnt_q <= 4'd0;
      level_cnt_q   <= 16'd0;
      lock_cnt_q    <= 8'd0;
`ifdef AUTO_RESTART_EN
      auto_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      death_q       <= death_d;
      speed_q       <= speed_d;
      collide_cnt_q <= collide_cnt_d;
      level_cnt_q   <= level_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
`ifdef AUTO_RESTART_EN
      auto_cnt_q    <= auto_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    death_d       = 1'b0;
    speed_d       = speed_q;
    collide_cnt_d = collide_cnt_q;
    level_cnt_d   = level_cnt_q;
    lock_cnt_d    = lock_cnt_q;
`ifdef AUTO_RESTART_EN
    auto_cnt_d    = auto_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (jump_rise) begin
          state_d       = ST_RUN;
          start_d       = 1'b1;
          collide_cnt_d = 4'd0;
          level_cnt_d   = 16'd0;
          speed_d       = 4'd0;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          // Level update is independent of death so a final wrap still shows.
          if (level_cnt_q == LEVEL_LAST) begin
            level_cnt_d = 16'd0;
            if (speed_q < LEVEL_MAX) speed_d = speed_q + 4'd1;
          end else begin
            level_cnt_d = level_cnt_q + 16'd1;
          end
          if (collide_sync[1]) begin
            if (collide_cnt_q + 4'd1 == COLLIDE_LIM) begin
              state_d       = ST_DEAD;
              death_d       = 1'b1;
              collide_cnt_d = 4'd0;
              lock_cnt_d    = LOCK_INIT;
`ifdef AUTO_RESTART_EN
              auto_cnt_d    = 8'd0;
`endif
            end else begin
              collide_cnt_d = collide_cnt_q + 4'd1;
            end
          end else begin
            collide_cnt_d = 4'd0;
          end
        end
      end
      ST_DEAD: begin
        if (jump_rise && lock_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          speed_d = 4'd0;
        end else if (frame_tick) begin
          if (lock_cnt_q != 8'd0) begin
            lock_cnt_d = lock_cnt_q - 8'd1;
          end
`ifdef AUTO_RESTART_EN
          else if (auto_cnt_q + 8'd1 == LOCK_INIT) begin
            state_d    = ST_IDLE;
            speed_d    = 4'd0;
            auto_cnt_d = 8'd0;
          end else begin
            auto_cnt_d = auto_cnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        speed_d = 4'd0;
      end
    endcase
  end

  assign state       = state_q;
  assign run         = (state_q == ST_RUN);
  assign start_pulse = start_q;
  assign death_pulse = death_q;
  assign speed_level = speed_q;

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Upstream producer of the game-state bus that the top-level colour, scroll, score and obstacle logic consumes.
- Runs the IDLE/RUN/DEAD game FSM from the debounced jump button and the top-level collision flag.
- Filters collision glitches over frame ticks and locks out restarts after a death.
- Generates a speed-level output that the scroll and obstacle delegates use to accelerate.

Parameters:
- COLLIDE_FRAMES, 2, consecutive frame ticks with collide high required to register a death (1..15)
- LOCK_FRAMES, 30, frame ticks in DEAD during which jump is ignored (1..255)
- LEVEL_FRAMES, 600, RUN frame ticks per speed-level increment (1..65535)
- MAX_LEVEL, 7, saturation value of speed_level (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_clk  in  1  divided frame clock, a level signal; its rising edge is the frame tick
- jump  in  1  debounced jump button, level
- collide  in  1  dino/obstacle overlap flag, level, may glitch
- state  out  2  00 IDLE, 01 RUN, 10 DEAD (11 never driven)
- run  out  1  high iff state==RUN
- start_pulse  out  1  one clk pulse on IDLE->RUN
- death_pulse  out  1  one clk pulse on RUN->DEAD
- speed_level  out  4  0..MAX_LEVEL

Behaviour:
- Reset (async assert, sync release):
  - state=00, run=0, pulses=0, speed_level=0
  - all counters and synchroniser flops cleared; jump_prev treated as 1, so a held button does not start the game at reset release.
- Input synchronisation: frame_clk, jump and collide each pass through a 2-flop synchroniser.
- Edge detection:
  - frame_tick = synced frame_clk rising edge, one clk wide.
  - jump_rise = synced jump rising edge.
- Latency: jump pin rising edge to state change is exactly 3 clk (2 sync + 1 register).
- IDLE:
  - jump_rise -> RUN; start_pulse for that 1 clk.
  - Entering RUN clears the collide counter, the level counter and speed_level.
- RUN:
  - On each frame_tick: if synced collide=1, the collide counter increments; else it clears.
  - When the counter would reach COLLIDE_FRAMES -> DEAD on that clk; death_pulse for 1 clk.
  - A frame_tick with collide low resets the counter, so non-consecutive hits never accumulate.
  - Speed: on each frame_tick in RUN the 16-bit level counter increments. At LEVEL_FRAMES-1 it wraps to 0 and speed_level increments, saturating at MAX_LEVEL.
  - Death on the same tick as a level wrap: DEAD wins; speed_level still updates (frozen value then shown).
  - jump is ignored in RUN.
- DEAD:
  - Lock counter loads LOCK_FRAMES on entry and decrements on each frame_tick until it reaches 0.
  - jump_rise while lock>0 is ignored. A jump held through the lockout does not restart: a fresh rising edge is needed.
  - jump_rise with lock==0 -> IDLE.
  - speed_level is held in DEAD and cleared on entry to IDLE.
- Simultaneous events:
  - frame_tick and jump_rise in the same clk: state transition evaluated first, counters follow the new state's rules next tick.
- Reset mid-operation: immediate return to IDLE and all outputs at reset values; no pulse is emitted.
- Outputs are registered; run is decoded from the state register only.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- When defined:
  - In DEAD, after the lock counter hits 0, a further LOCK_FRAMES frame ticks without jump_rise force DEAD->IDLE automatically.
  - Any jump_rise after lock==0 still restarts immediately.
- When undefined: DEAD persists until jump_rise or rst.

Test Plan:
- Reset with jump held high, release rst -> state stays 00 for 100 frame ticks; drop jump, raise jump -> state=01 exactly 3 clk later, start_pulse 1 clk wide.
- RUN, COLLIDE_FRAMES=2: collide high for 1 tick, low for 1, high for 1 -> remains 01. Then high for 2 consecutive ticks -> state=10, death_pulse=1 for 1 clk.
- DEAD, LOCK_FRAMES=30:
  - jump pulses at ticks 5 and 29 -> stays 10.
  - jump pulse after tick 30 -> state=00, speed_level=0.
- LEVEL_FRAMES=4, MAX_LEVEL=3: 20 ticks in RUN, no collide -> speed_level 1 at tick 4, 2 at tick 8, 3 at tick 12, still 3 at tick 20.
- Assert rst mid-RUN with speed_level=2 and collide counter=1 -> state=00, speed_level=0, no death_pulse. A new jump starts a fresh run needing 2 collide ticks.
- AUTO_RESTART_EN defined, LOCK_FRAMES=30: die, no jump -> state=00 at frame tick 60 after death; undefined build -> still 10 at tick 200.
